// File: rtl/tt_check_pkg.sv
// tt_check_pkg: shared state encoding and default sizing for the truth-table vector checker
package tt_check_pkg;
    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 3;
    localparam int NUM_VEC    = 2 ** N_IN_DEF;
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
endpackage

// File: rtl/tt_vector_checker_if.sv
// tt_vector_checker_if: start/table/result bus between a controller and the checker, plus the DUT vector/response pair
interface tt_vector_checker_if #(parameter int N_IN = tt_check_pkg::N_IN_DEF);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic [N_IN-1:0]      vec;
    logic                 z;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail;
    logic                 fail_valid;
    modport master (output start, expected, z, input vec, busy, done, pass, err_count, first_fail, fail_valid);
    modport slave  (input start, expected, z, output vec, busy, done, pass, err_count, first_fail, fail_valid);
endinterface

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: up-counter that flags the last settle cycle of a held vector
module tt_settle_timer
    import tt_check_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_expire
);
    logic [3:0] r_cnt;
    // count while enabled; clear parks the counter at 0 so each WAIT starts fresh
    always_ff @(posedge clk) begin
        if (!rst_n)       r_cnt <= 4'd0;
        else if (i_clear) r_cnt <= 4'd0;
        else              r_cnt <= r_cnt + 4'd1;
    end
    assign o_expire = (r_cnt == 4'(SETTLE - 1));
endmodule

// File: rtl/tt_vector_checker.sv
// tt_vector_checker: steps every input vector onto a combinational DUT and scores its response against a truth table
module tt_vector_checker
    import tt_check_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    tt_vector_checker_if.slave bus
);
    localparam int              NV   = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);

    state_t            r_state, w_next;
    logic [NV-1:0]     r_exp;
    logic [N_IN-1:0]   r_vec, r_first;
    logic [N_IN:0]     r_err, w_err_nxt;
    logic              r_pass, r_fv;
    logic              w_expire, w_mis, w_last;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != WAIT),
        .o_expire (w_expire)
    );

    assign w_mis     = (r_state == SAMPLE) && (bus.z != r_exp[r_vec]);
    assign w_last    = (r_vec == LAST);
    assign w_err_nxt = r_err + (N_IN+1)'(w_mis);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: WAIT holds SETTLE cycles, SAMPLE is one cycle per vector, DONE one cycle per run
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? WAIT : IDLE;
            WAIT:    w_next = w_expire ? SAMPLE : WAIT;
            SAMPLE:  w_next = w_last ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // run datapath: latch table at start, score each sample, fold the last sample into pass
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp   <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_fv    <= 1'b0;
            r_pass  <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_exp   <= bus.expected;
            r_vec   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_fv    <= 1'b0;
            r_pass  <= 1'b0;
        end else if (r_state == SAMPLE) begin
            r_err <= w_err_nxt;
            if (w_mis && !r_fv) begin
                r_first <= r_vec;
                r_fv    <= 1'b1;
            end
            if (w_last) r_pass <= (w_err_nxt == '0);
            else        r_vec  <= r_vec + N_IN'(1);
        end else if (r_state == DONE) begin
            r_vec <= '0;
        end
    end

    // outputs: status decoded from state, results straight from their registers
    always_comb begin
        bus.vec        = r_vec;
        bus.busy       = (r_state == WAIT) || (r_state == SAMPLE);
        bus.done       = (r_state == DONE);
        bus.pass       = r_pass;
        bus.err_count  = r_err;
        bus.first_fail = r_first;
        bus.fail_valid = r_fv;
    end
endmodule

// File: tb/tb_tt_vector_checker.sv
// tb_tt_vector_checker: table-driven and randomized runs of the vector checker against a truth-table model
module tb_tt_vector_checker;
    localparam int N   = 4;
    localparam int S   = 3;
    localparam int NV  = 16;
    localparam int LAT = 1 + NV * (S + 1);

    typedef struct {
        logic [15:0] tt;
        logic [15:0] ex;
        int          err;
        int          first;
        logic        fv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dut_tt = 16'h0;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[5];

    always #5 clk = ~clk;

    tt_vector_checker_if #(.N_IN(N)) bus();
    // the modelled gate under test: its response is simply its own truth table indexed by the vector
    assign bus.z = dut_tt[bus.vec];

    tt_vector_checker #(.N_IN(N), .SETTLE(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // reference: mismatches are the bits where the DUT table differs from the expected table
    task automatic model(input logic [15:0] tt, input logic [15:0] ex, output int e, output int f, output logic fv);
        logic [15:0] diff;
        diff = tt ^ ex;
        e  = $countones(diff);
        fv = (diff != 16'h0);
        f  = 0;
        for (int i = 15; i >= 0; i--) if (diff[i]) f = i;
    endtask

    task automatic chk_reset();
        chk("rst_vec", bus.vec, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_count, 0);
        chk("rst_first", bus.first_fail, 0);
        chk("rst_fv", bus.fail_valid, 0);
    endtask

    // one full run; poke>0 re-pulses start and flips expected at that cycle to prove both are ignored
    task automatic run(input logic [15:0] tt, input logic [15:0] ex, input int poke,
                       input int e, input int f, input logic fv);
        int lat;
        dut_tt       = tt;
        bus.expected = ex;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= LAT + 20; c++) begin
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            chk("vec", bus.vec, (c - 1) / (S + 1));
            chk("busy", bus.busy, 1);
            if (c == poke) begin
                bus.start    = 1'b1;
                bus.expected = ~ex;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("latency", lat, LAT);
        chk("busy_done", bus.busy, 0);
        chk("vec_done", bus.vec, NV - 1);
        chk("err_count", bus.err_count, e);
        chk("first_fail", bus.first_fail, f);
        chk("fail_valid", bus.fail_valid, fv);
        chk("pass", bus.pass, e == 0);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
        chk("vec_idle", bus.vec, 0);
        chk("busy_idle", bus.busy, 0);
        chk("err_hold", bus.err_count, e);
        chk("pass_hold", bus.pass, e == 0);
    endtask

    initial begin
        int          e, f;
        logic        fv;
        logic [15:0] rt, re;
        bus.start    = 1'b0;
        bus.expected = 16'h0;
        tbl[0] = '{16'h0000, 16'h0000, 0, 0, 1'b0};
        tbl[1] = '{16'h8000, 16'h8000, 0, 0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 2, 0, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0000, 16, 0, 1'b1};
        tbl[4] = '{16'h02FF, 16'h00FF, 1, 9, 1'b1};
        repeat (2) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run(tbl[i].tt, tbl[i].ex, 0, tbl[i].err, tbl[i].first, tbl[i].fv);

        // restart and table change mid-run must not disturb the latched table
        run(16'h02FF, 16'h00FF, 10, 1, 9, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rt = 16'($urandom);
            re = 16'($urandom);
            model(rt, re, e, f, fv);
            run(rt, re, 0, e, f, fv);
        end

        run(16'h8000, 16'h8000, 0, 0, 0, 1'b0);

        // reset in the middle of a failing run
        dut_tt       = 16'hFFFF;
        bus.expected = 16'h0000;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 100 && bus.vec != 4'd5; i++) @(negedge clk);
        chk("reach_vec5", bus.vec, 5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", bus.done, 0);
        end
        run(16'hFFFF, 16'hFFFF, 0, 0, 0, 1'b0);

        // reset wins over a simultaneous start
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        chk("rst_start_busy", bus.busy, 0);
        @(negedge clk);
        chk("rst_start_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
